// File: rtl/booth_radix4_mult.sv
// Radix-4 (modified) Booth sequential multiplier.
// Retires two multiplier bits per cycle; signed or unsigned per operation.
module booth_radix4_mult #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N/2+2)
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  iter
);

  localparam logic [CW-1:0] LAST = CW'(N/2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q;
  logic [N+2:0]   a_q;
  logic [N+1:0]   q_q;
  logic [N+1:0]   m_q;
  logic           qm1_q;
  logic [2*N-1:0] product_q;
  logic           busy_q;
  logic           done_q;
  logic [CW-1:0]  iter_q;

  logic [N+2:0]   mx;
  logic [N+2:0]   m2;
  logic [N+2:0]   addend;
  logic [N+2:0]   sum;
  logic [N+2:0]   a_d;
  logic [N+1:0]   q_d;
  logic [2*N-1:0] product_d;
  logic [2:0]     dig;
  logic           ext;

  always_comb begin
    mx  = {m_q[N+1], m_q};
    m2  = {m_q, 1'b0};
    dig = {q_q[1:0], qm1_q};
    unique case (dig)
      3'b001, 3'b010: addend = mx;
      3'b011:         addend = m2;
      3'b100:         addend = ~m2 + (N+3)'(1);
      3'b101, 3'b110: addend = ~mx + (N+3)'(1);
      default:        addend = '0;
    endcase
    sum = a_q + addend;
    // add, then arithmetic shift of {A, Q, q_-1} by two
    a_d       = {{2{sum[N+2]}}, sum[N+2:2]};
    q_d       = {sum[1:0], q_q[N+1:2]};
    product_d = {a_d[N-3:0], q_d};
    ext       = signed_mode;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      iter_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            m_q     <= {{2{ext & multiplicand[N-1]}}, multiplicand};
            q_q     <= {{2{ext & multiplier[N-1]}}, multiplier};
            qm1_q   <= 1'b0;
            a_q     <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          qm1_q <= q_q[1];
          if (iter_q == LAST) begin
            product_q <= product_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            iter_q    <= '0;
            state_q   <= IDLE;
          end else begin
            iter_q <= iter_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign iter    = iter_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Scoreboard bench for booth_radix4_mult at N=8 and N=16.
// Driver pushes expected products; monitors pop on each done rise.
module tb_booth_radix4_mult;

  localparam int K8  = 5;
  localparam int K16 = 9;

  typedef struct {
    logic [31:0] p;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        st8, sm8, busy8, done8;
  logic [7:0]  mc8, mp8;
  logic [15:0] p8;
  logic [2:0]  it8;
  logic        st16, sm16, busy16, done16;
  logic [15:0] mc16, mp16;
  logic [31:0] p16;
  logic [3:0]  it16;

  int   ncmp = 0;
  int   nerr = 0;
  int   cyc  = 0;
  logic d8p  = 1'b0;
  logic d16p = 1'b0;
  exp_t sb8[$];
  exp_t sb16[$];

  booth_radix4_mult #(.N(8)) u8 (
    .Clock(clk), .Reset(rst), .start(st8), .signed_mode(sm8),
    .multiplicand(mc8), .multiplier(mp8),
    .product(p8), .busy(busy8), .done(done8), .iter(it8)
  );

  booth_radix4_mult #(.N(16)) u16 (
    .Clock(clk), .Reset(rst), .start(st16), .signed_mode(sm16),
    .multiplicand(mc16), .multiplier(mp16),
    .product(p16), .busy(busy16), .done(done16), .iter(it16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref8(logic [7:0] m, logic [7:0] q,
                                       logic s);
    logic [15:0] a, b;
    a = s ? {{8{m[7]}}, m} : {8'b0, m};
    b = s ? {{8{q[7]}}, q} : {8'b0, q};
    return a * b;
  endfunction

  function automatic logic [31:0] ref16(logic [15:0] m, logic [15:0] q,
                                        logic s);
    logic [31:0] a, b;
    a = s ? {{16{m[15]}}, m} : {16'b0, m};
    b = s ? {{16{q[15]}}, q} : {16'b0, q};
    return a * b;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done8 && !d8p) begin
      if (sb8.size() == 0) begin
        check("unexpected_done8", 32'(sb8.size()), 32'd1);
      end else begin
        e = sb8.pop_front();
        check("prod8", {16'b0, p8}, e.p);
        check("lat8", 32'(cyc), 32'(e.acc + K8));
      end
    end
    d8p = done8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done16 && !d16p) begin
      if (sb16.size() == 0) begin
        check("unexpected_done16", 32'(sb16.size()), 32'd1);
      end else begin
        e = sb16.pop_front();
        check("prod16", p16, e.p);
        check("lat16", 32'(cyc), 32'(e.acc + K16));
      end
    end
    d16p = done16;
  end

  task automatic go8(input logic [7:0] m, input logic [7:0] q,
                     input logic s, input logic [15:0] exp);
    exp_t e;
    @(negedge clk);
    mc8 = m; mp8 = q; sm8 = s; st8 = 1'b1;
    e.p = {16'b0, exp};
    e.acc = cyc + 1;
    sb8.push_back(e);
    @(negedge clk);
    st8 = 1'b0;
    check("busy8_run", {31'b0, busy8}, 32'd1);
    check("done8_clr", {31'b0, done8}, 32'd0);
    repeat (K8 - 1) @(negedge clk);
  endtask

  task automatic go16(input logic [15:0] m, input logic [15:0] q,
                      input logic s, input logic [31:0] exp);
    exp_t e;
    @(negedge clk);
    mc16 = m; mp16 = q; sm16 = s; st16 = 1'b1;
    e.p = exp;
    e.acc = cyc + 1;
    sb16.push_back(e);
    @(negedge clk);
    st16 = 1'b0;
    check("busy16_run", {31'b0, busy16}, 32'd1);
    repeat (K16 - 1) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  r8a, r8b;
    logic [15:0] r16a, r16b;
    logic        rs;
    rst = 1'b1;
    st8 = 1'b0; sm8 = 1'b0; mc8 = '0; mp8 = '0;
    st16 = 1'b0; sm16 = 1'b0; mc16 = '0; mp16 = '0;
    repeat (2) @(negedge clk);
    check("rst_prod8", {16'b0, p8}, 32'd0);
    check("rst_busy8", {31'b0, busy8}, 32'd0);
    check("rst_done8", {31'b0, done8}, 32'd0);
    check("rst_iter8", 32'(it8), 32'd0);
    check("rst_prod16", p16, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    go8(8'hFD, 8'h07, 1'b1, 16'hFFEB);
    repeat (4) @(negedge clk);
    check("hold_prod8", {16'b0, p8}, 32'h0000FFEB);
    check("hold_done8", {31'b0, done8}, 32'd1);
    check("hold_busy8", {31'b0, busy8}, 32'd0);

    go8(8'h80, 8'h80, 1'b1, 16'h4000);
    go8(8'h80, 8'h80, 1'b0, 16'h4000);
    go8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    go8(8'hFF, 8'hFF, 1'b1, 16'h0001);

    // start pulsed mid-run with new operands must be ignored
    @(negedge clk);
    mc8 = 8'h05; mp8 = 8'h06; sm8 = 1'b1; st8 = 1'b1;
    begin
      exp_t e;
      e.p = 32'h0000001E;
      e.acc = cyc + 1;
      sb8.push_back(e);
    end
    @(negedge clk);
    st8 = 1'b0;
    @(negedge clk);
    mc8 = 8'h7F; mp8 = 8'h7F; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (K8 - 3) @(negedge clk);
    go8(8'h7F, 8'h7F, 1'b1, 16'h3F01);

    // reset in the middle of a run
    @(negedge clk);
    mc8 = 8'h12; mp8 = 8'h34; sm8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_prod8", {16'b0, p8}, 32'd0);
    check("abort_busy8", {31'b0, busy8}, 32'd0);
    check("abort_done8", {31'b0, done8}, 32'd0);
    check("abort_iter8", 32'(it8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("idle_busy8", {31'b0, busy8}, 32'd0);
    check("idle_done8", {31'b0, done8}, 32'd0);
    check("idle_prod8", {16'b0, p8}, 32'd0);

    go16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
    go16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    go16(16'h8000, 16'h8000, 1'b1, 32'h40000000);
    go16(16'h0003, 16'hFFFD, 1'b1, 32'hFFFFFFF7);

    for (int i = 0; i < 150; i++) begin
      r8a = 8'($urandom);
      r8b = 8'($urandom);
      rs  = 1'($urandom);
      go8(r8a, r8b, rs, ref8(r8a, r8b, rs));
    end
    for (int i = 0; i < 150; i++) begin
      r16a = 16'($urandom);
      r16b = 16'($urandom);
      rs   = 1'($urandom);
      go16(r16a, r16b, rs, ref16(r16a, r16b, rs));
    end

    repeat (20) @(negedge clk);
    check("sb8_left", 32'(sb8.size()), 32'd0);
    check("sb16_left", 32'(sb16.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
